sprite_engine: RTL and testbench

- Parametrised successor of the fixed 40x24 combinational sprite painter.
- Owns the sprite position registers and moves the sprite once per video frame, bouncing off the screen edges.
- Cycles through NFRAMES animation frames and supports horizontal mirroring.
- Drives a synchronous (1-cycle latency) sprite ROM and emits a pipelined paint bit for the pixel mixer.

---
 rtl/sprite_engine.sv | 168 ++++++++++++++++
 tb/tb_sprite_engine.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_engine.sv
// sprite_engine: owns the sprite position, bounces it off the screen edges once
// per video frame, steps the animation and turns pixel coordinates into a paint
// bit using a 1-cycle synchronous sprite ROM.
module sprite_engine #(
    parameter int SPR_W    = 40,
    parameter int SPR_H    = 24,
    parameter int NFRAMES  = 4,
    parameter int COORD_W  = 11,
    parameter int SCR_W    = 640,
    parameter int SCR_H    = 480,
    parameter int X0       = 0,
    parameter int Y0       = 0,
    parameter int ANIM_DIV = 8,
    parameter int ADDR_W   = $clog2(SPR_H*NFRAMES)
) (
    input  logic                         clk_i,
    input  logic                         rst_n_i,
    input  logic                         frame_start_i,
    input  logic                         pix_valid_i,
    input  logic [COORD_W-1:0]           pix_x_i,
    input  logic [COORD_W-1:0]           pix_y_i,
    input  logic                         move_en_i,
    input  logic [3:0]                   speed_i,
    input  logic                         mirror_i,
    output logic [ADDR_W-1:0]            rom_addr_o,
    input  logic [SPR_W-1:0]             rom_data_i,
    output logic                         paint_o,
    output logic [COORD_W-1:0]           pos_x_o,
    output logic [COORD_W-1:0]           pos_y_o,
    output logic [$clog2(NFRAMES)-1:0]   anim_frame_o,
    output logic                         bounce_o
);

    localparam int AF_W  = $clog2(NFRAMES);
    localparam int CNT_W = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
    localparam int COL_W = $clog2(SPR_W);
    localparam int SW    = COORD_W + 2;   // signed width for the motion step
    localparam int HW    = COORD_W + 1;   // hit-test width, sums never wrap
    localparam logic signed [SW-1:0] X_MAX = SW'(SCR_W - SPR_W);
    localparam logic signed [SW-1:0] Y_MAX = SW'(SCR_H - SPR_H);

    logic [COORD_W-1:0] pos_x_q, pos_x_d, pos_y_q, pos_y_d;
    logic               xneg_q, xneg_d, yneg_q, yneg_d;    // 1 = moving toward 0
    logic [AF_W-1:0]    anim_q, anim_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               mirror_q, mirror_d;
    logic               bounce_q, bounce_d;
    logic               hit_q, hit_d;
    logic [COL_W-1:0]   col_q, col_d;

    logic signed [SW-1:0] spd_s, cur_x, cur_y, nx, ny;
    logic                 bx, by;

    // Frame-rate update: motion with edge reflection, animation divider, mirror latch
    always_comb begin
        pos_x_d  = pos_x_q;
        pos_y_d  = pos_y_q;
        xneg_d   = xneg_q;
        yneg_d   = yneg_q;
        anim_d   = anim_q;
        cnt_d    = cnt_q;
        mirror_d = mirror_q;
        bounce_d = 1'b0;
        bx       = 1'b0;
        by       = 1'b0;
        spd_s    = {{(SW-4){1'b0}}, speed_i};
        cur_x    = {2'b00, pos_x_q};
        cur_y    = {2'b00, pos_y_q};
        nx       = xneg_q ? (cur_x - spd_s) : (cur_x + spd_s);
        ny       = yneg_q ? (cur_y - spd_s) : (cur_y + spd_s);
        if (frame_start_i) begin
            mirror_d = mirror_i;
            if (cnt_q == CNT_W'(ANIM_DIV - 1)) begin
                cnt_d  = '0;
                anim_d = (anim_q == AF_W'(NFRAMES - 1)) ? '0 : anim_q + 1'b1;
            end else begin
                cnt_d  = cnt_q + 1'b1;
            end
            if (move_en_i) begin
                if (!xneg_q && nx > X_MAX) begin
                    pos_x_d = X_MAX[COORD_W-1:0];
                    xneg_d  = 1'b1;
                    bx      = 1'b1;
                end else if (xneg_q && nx < 0) begin
                    pos_x_d = '0;
                    xneg_d  = 1'b0;
                    bx      = 1'b1;
                end else begin
                    pos_x_d = nx[COORD_W-1:0];
                end
                if (!yneg_q && ny > Y_MAX) begin
                    pos_y_d = Y_MAX[COORD_W-1:0];
                    yneg_d  = 1'b1;
                    by      = 1'b1;
                end else if (yneg_q && ny < 0) begin
                    pos_y_d = '0;
                    yneg_d  = 1'b0;
                    by      = 1'b1;
                end else begin
                    pos_y_d = ny[COORD_W-1:0];
                end
                bounce_d = bx | by;
            end
        end
    end

    logic [HW-1:0]      px_w, py_w, x_lo, y_lo, x_hi, y_hi;
    logic [COORD_W-1:0] row, colx;

    // Stage 0: hit test against the current (pre-update) position and ROM address
    always_comb begin
        px_w  = {1'b0, pix_x_i};
        py_w  = {1'b0, pix_y_i};
        x_lo  = {1'b0, pos_x_q};
        y_lo  = {1'b0, pos_y_q};
        x_hi  = x_lo + HW'(SPR_W);
        y_hi  = y_lo + HW'(SPR_H);
        hit_d = pix_valid_i && (py_w >= y_lo) && (py_w < y_hi)
                            && (px_w >= x_lo) && (px_w < x_hi);
        row   = pix_y_i - pos_y_q;
        colx  = pix_x_i - pos_x_q;
        col_d = COL_W'(colx);
        rom_addr_o = '0;
        if (hit_d)
            rom_addr_o = ADDR_W'(anim_q) * ADDR_W'(SPR_H) + ADDR_W'(row);
    end

    logic [COL_W-1:0] bit_idx;

    // Stage 1: pick the pixel from the returned ROM word; column 0 is the MSB unless mirrored
    always_comb begin
        bit_idx = mirror_q ? col_q : (COL_W'(SPR_W - 1) - col_q);
        paint_o = hit_q & rom_data_i[bit_idx];
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            pos_x_q  <= COORD_W'(X0);
            pos_y_q  <= COORD_W'(Y0);
            xneg_q   <= 1'b0;
            yneg_q   <= 1'b0;
            anim_q   <= '0;
            cnt_q    <= '0;
            mirror_q <= 1'b0;
            bounce_q <= 1'b0;
            hit_q    <= 1'b0;
            col_q    <= '0;
        end else begin
            pos_x_q  <= pos_x_d;
            pos_y_q  <= pos_y_d;
            xneg_q   <= xneg_d;
            yneg_q   <= yneg_d;
            anim_q   <= anim_d;
            cnt_q    <= cnt_d;
            mirror_q <= mirror_d;
            bounce_q <= bounce_d;
            hit_q    <= hit_d;
            col_q    <= col_d;
        end
    end

    assign pos_x_o      = pos_x_q;
    assign pos_y_o      = pos_y_q;
    assign anim_frame_o = anim_q;
    assign bounce_o     = bounce_q;

endmodule

// File: tb/tb_sprite_engine.sv
// Bench for sprite_engine: directed stimulus, a frame-level behavioural model
// compared every cycle, plus literal expectations from hand calculation.
module tb_sprite_engine;

    localparam int SPR_W   = 40;
    localparam int SPR_H   = 24;
    localparam int NFRAMES = 4;
    localparam int COORD_W = 11;
    localparam int ADIV    = 8;
    localparam int ADDR_W  = 7;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst_n, fs_a, fs_b, pv, move_en, mirror;
    logic [COORD_W-1:0] px, py;
    logic [3:0]         spd_a, spd_b;

    logic [ADDR_W-1:0]  rom_addr_a, rom_addr_b;
    logic [SPR_W-1:0]   rom_data_a;
    logic               paint_a, paint_b, bounce_a, bounce_b;
    logic [COORD_W-1:0] pos_x_a, pos_y_a, pos_x_b, pos_y_b;
    logic [1:0]         anim_a, anim_b;

    sprite_engine #(.X0(100), .Y0(50)) dut_a (
        .clk_i(clk), .rst_n_i(rst_n), .frame_start_i(fs_a), .pix_valid_i(pv),
        .pix_x_i(px), .pix_y_i(py), .move_en_i(move_en), .speed_i(spd_a),
        .mirror_i(mirror), .rom_addr_o(rom_addr_a), .rom_data_i(rom_data_a),
        .paint_o(paint_a), .pos_x_o(pos_x_a), .pos_y_o(pos_y_a),
        .anim_frame_o(anim_a), .bounce_o(bounce_a));

    // Square travel range (600x600) so both axes reach a corner together
    sprite_engine #(.SCR_H(624)) dut_b (
        .clk_i(clk), .rst_n_i(rst_n), .frame_start_i(fs_b), .pix_valid_i(1'b0),
        .pix_x_i(px), .pix_y_i(py), .move_en_i(move_en), .speed_i(spd_b),
        .mirror_i(mirror), .rom_addr_o(rom_addr_b), .rom_data_i({SPR_W{1'b0}}),
        .paint_o(paint_b), .pos_x_o(pos_x_b), .pos_y_o(pos_y_b),
        .anim_frame_o(anim_b), .bounce_o(bounce_b));

    logic [SPR_W-1:0] rom [SPR_H*NFRAMES];
    always @(posedge clk) rom_data_a <= rom[rom_addr_a];

    // Model state, index 0 = dut_a, 1 = dut_b
    int m_x[2], m_y[2], m_dx[2], m_dy[2], m_cnt[2], m_anim[2];
    bit m_mir[2], m_bnc[2];
    bit exp_paint, chk_en;
    int errors, checks;

    function automatic int xlim(int k); return 600; endfunction
    function automatic int ylim(int k); return (k == 0) ? 456 : 600; endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_x[0] = 100; m_y[0] = 50; m_x[1] = 0; m_y[1] = 0;
        for (int k = 0; k < 2; k++) begin
            m_dx[k] = 1; m_dy[k] = 1; m_cnt[k] = 0; m_anim[k] = 0;
            m_mir[k] = 0; m_bnc[k] = 0;
        end
        exp_paint = 0;
    endtask

    task automatic model_frame(input int k, input bit me, input int spd, input bit mir);
        int nx, ny;
        bit b;
        m_mir[k] = mir;
        m_cnt[k]++;
        if (m_cnt[k] == ADIV) begin
            m_cnt[k] = 0;
            m_anim[k] = (m_anim[k] + 1) % NFRAMES;
        end
        b = 0;
        if (me) begin
            nx = m_x[k] + m_dx[k]*spd;
            ny = m_y[k] + m_dy[k]*spd;
            if (nx > xlim(k))  begin m_x[k] = xlim(k); m_dx[k] = -1; b = 1; end
            else if (nx < 0)   begin m_x[k] = 0;       m_dx[k] = 1;  b = 1; end
            else m_x[k] = nx;
            if (ny > ylim(k))  begin m_y[k] = ylim(k); m_dy[k] = -1; b = 1; end
            else if (ny < 0)   begin m_y[k] = 0;       m_dy[k] = 1;  b = 1; end
            else m_y[k] = ny;
        end
        m_bnc[k] = b;
    endtask

    function automatic bit m_hit(input bit v, input int x, input int y);
        return v && x >= m_x[0] && x < m_x[0] + SPR_W && y >= m_y[0] && y < m_y[0] + SPR_H;
    endfunction

    function automatic bit m_paint(input bit v, input int x, input int y);
        logic [SPR_W-1:0] w;
        int c;
        if (!m_hit(v, x, y)) return 0;
        w = rom[m_anim[0]*SPR_H + (y - m_y[0])];
        c = x - m_x[0];
        return m_mir[0] ? w[c] : w[SPR_W-1-c];
    endfunction

    function automatic int m_addr(input bit v, input int x, input int y);
        return m_hit(v, x, y) ? m_anim[0]*SPR_H + (y - m_y[0]) : 0;
    endfunction

    // Every cycle: outputs of both instances against the model
    always @(negedge clk) begin
        if (chk_en) begin
            chk("pos_x_a", pos_x_a, m_x[0]);
            chk("pos_y_a", pos_y_a, m_y[0]);
            chk("anim_a", anim_a, m_anim[0]);
            chk("bounce_a", bounce_a, m_bnc[0]);
            chk("paint_a", paint_a, exp_paint);
            chk("rom_addr_a", rom_addr_a, m_addr(pv, int'(px), int'(py)));
            chk("pos_x_b", pos_x_b, m_x[1]);
            chk("pos_y_b", pos_y_b, m_y[1]);
            chk("anim_b", anim_b, m_anim[1]);
            chk("bounce_b", bounce_b, m_bnc[1]);
            chk("paint_b", paint_b, 0);
            chk("rom_addr_b", rom_addr_b, 0);
        end
    end

    task automatic tick();
        bit pend;
        pend = m_paint(pv, int'(px), int'(py));
        @(posedge clk);
        #1;
        exp_paint = pend;
        m_bnc[0] = 0;
        m_bnc[1] = 0;
    endtask

    task automatic do_reset();
        rst_n = 0;
        tick();
        model_reset();
        chk_en = 1;
        rst_n = 1;
        fs_a = 0;
    endtask

    task automatic frame_a(input bit me, input int spd);
        move_en = me; spd_a = 4'(spd); fs_a = 1;
        tick();
        fs_a = 0;
        model_frame(0, me, spd, mirror);
    endtask

    task automatic frame_b(input int spd);
        move_en = 1; spd_b = 4'(spd); fs_b = 1;
        tick();
        fs_b = 0;
        model_frame(1, 1, spd, mirror);
    endtask

    task automatic pixel(input int x, input int y);
        pv = 1; px = COORD_W'(x); py = COORD_W'(y);
        tick();
    endtask

    task automatic idle();
        pv = 0;
        tick();
    endtask

    initial begin
        logic [63:0] r;
        rst_n = 1; fs_a = 0; fs_b = 0; pv = 0; px = 0; py = 0;
        move_en = 0; mirror = 0; spd_a = 0; spd_b = 0;
        errors = 0; checks = 0; chk_en = 0;
        for (int i = 0; i < SPR_H*NFRAMES; i++) begin
            r = {$urandom(), $urandom()};
            rom[i] = r[SPR_W-1:0];
        end
        model_reset();

        // Reset values
        do_reset();
        chk("rst_pos_x", pos_x_a, 100);
        chk("rst_pos_y", pos_y_a, 50);
        chk("rst_anim", anim_a, 0);
        chk("rst_paint", paint_a, 0);
        chk("rst_bounce", bounce_a, 0);

        // Paint, unmirrored: column 0 is bit 39
        rom[0] = 40'h80_0000_0001;
        pixel(100, 50); chk("p_100_m0", paint_a, 1);
        pixel(139, 50); chk("p_139_m0", paint_a, 1);
        pixel(101, 50); chk("p_101_m0", paint_a, 0);
        pixel(140, 50); chk("p_140_m0", paint_a, 0);
        pixel(99, 50);
        pixel(100, 73);
        pixel(100, 74);
        pixel(100, 49);
        pixel(120, 60);
        idle();

        // Mirror latched on a frame_start without motion
        mirror = 1;
        frame_a(0, 0);
        pixel(100, 50); chk("p_100_m1", paint_a, 1);
        pixel(139, 50); chk("p_139_m1", paint_a, 1);
        idle();
        rom[0] = 40'h80_0000_0000;
        pixel(100, 50); chk("p_100_m1_b", paint_a, 0);
        pixel(139, 50); chk("p_139_m1_b", paint_a, 1);
        idle();
        mirror = 0;
        frame_a(0, 0);

        // Basic motion and hold
        frame_a(1, 3);
        chk("mv_x", pos_x_a, 103);
        chk("mv_y", pos_y_a, 53);
        chk("mv_bounce", bounce_a, 0);
        frame_a(0, 3);
        chk("hold_x", pos_x_a, 103);
        chk("hold_y", pos_y_a, 53);

        // Reset coinciding with a frame_start discards the motion
        move_en = 1; spd_a = 3; fs_a = 1;
        do_reset();
        chk("rst2_x", pos_x_a, 100);
        chk("rst2_y", pos_y_a, 50);

        // Animation divider and ROM address
        repeat (8) frame_a(0, 0);
        chk("anim_8", anim_a, 1);
        pv = 1; px = 100; py = 55;
        #1;
        chk("rom_addr_f1r5", rom_addr_a, 29);
        tick();
        idle();
        repeat (24) frame_a(0, 0);
        chk("anim_32", anim_a, 0);

        // Right-edge reflection
        frame_a(1, 3);
        repeat (33) frame_a(1, 15);
        chk("x_598", pos_x_a, 598);
        frame_a(1, 5);
        chk("x_clamp", pos_x_a, 600);
        chk("bounce_r", bounce_a, 1);
        tick();
        chk("bounce_r_end", bounce_a, 0);
        frame_a(1, 5);
        chk("x_back", pos_x_a, 595);

        // speed 0: no motion, no bounce
        frame_a(1, 0);
        chk("spd0_x", pos_x_a, 595);
        chk("spd0_bounce", bounce_a, 0);

        // Pixels around the moved sprite
        for (int i = 0; i < 10; i++) pixel(588 + i*6, 350 + i*4);
        idle();

        // Corner reflections on the square-range instance
        repeat (40) frame_b(15);
        chk("b_600_x", pos_x_b, 600);
        chk("b_600_bounce", bounce_b, 0);
        frame_b(15);
        chk("b_far_x", pos_x_b, 600);
        chk("b_far_y", pos_y_b, 600);
        chk("b_far_bounce", bounce_b, 1);
        repeat (39) frame_b(15);
        chk("b_15", pos_x_b, 15);
        frame_b(13);
        chk("b_2_x", pos_x_b, 2);
        chk("b_2_y", pos_y_b, 2);
        frame_b(4);
        chk("b_0_x", pos_x_b, 0);
        chk("b_0_y", pos_y_b, 0);
        chk("b_0_bounce", bounce_b, 1);
        frame_b(4);
        chk("b_4_x", pos_x_b, 4);
        chk("b_4_y", pos_y_b, 4);
        chk("b_4_bounce", bounce_b, 0);
        tick();

        chk_en = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
